fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised, stateful forwarding and stall unit for the D-stage operand read of the pipelined MIPS core.
- Replaces per-source fixed forwarding MUXes with a scoreboard that tracks NSTG in-flight producers: destination register and remaining cycles until the result is available (Tnew).
- For each of NRP read ports it either supplies the newest forwarded value or raises a stall.
- Also owns the multiply/divide busy counter and its HI/LO stall.

Parameters:
- DW, 32, data width.
- AW, 5, register address width; address 0 is hard-wired zero.
- NSTG, 3, in-flight stages tracked after D (slot 0 = E, slot NSTG-1 = W).
- NRP, 2, number of D-stage read ports.
- TW, 3, width of Tnew/Tuse fields.
- MDU_LAT, 5, multiply/divide busy cycles; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  D-stage holds a real instruction.
- issue_wa  in  AW  destination of D instruction; 0 = no write.
- issue_tnew  in  TW  cycles after entering E until the result exists in the producing stage.
- issue_md_start  in  1  D instruction starts the MDU (mult/div/mthi/mtlo).
- issue_md_use  in  1  D instruction touches HI/LO; decoder asserts this for every MDU instruction.
- flush  in  1  force a bubble into slot 0 this cycle.
- rs_addr  in  NRP*AW  read addresses, port p at bits [p*AW +: AW].
- rs_tuse  in  NRP*TW  cycles until port p's value is consumed.
- rf_rdata  in  NRP*DW  register-file read data.
- stage_data  in  NSTG*DW  result currently held in slot i's pipeline register.
- fwd_data  out  NRP*DW  resolved operand per port.
- fwd_ready  out  NRP  port value is valid this cycle.
- stall  out  1  freeze PC/D; E receives a bubble.
- md_busy  out  1  MDU counter non-zero.

Behaviour:
- State:
  - Per slot i: v[i], wa[i], tn[i].
  - md_cnt, width clog2(MDU_LAT+1).
- Reset (async):
  - All v=0, wa=0, tn=0, md_cnt=0.
  - Consequently stall=0, md_busy=0, fwd_ready=all 1, fwd_data=rf_rdata (port addr 0 gives 0).
  - Reset mid-operation discards all in-flight entries and any MDU countdown immediately.
- accept = issue_valid & !stall & !flush.
- Every clock edge, slots shift; later stages never freeze:
  - Slot 0 <= accept ? {1, issue_wa, issue_tnew} : bubble {0, 0, 0}.
  - Slot i+1 <= {v[i], wa[i], sat0(tn[i]-1)} for i < NSTG-1.
  - Slot NSTG-1's old contents retire.
- stall and flush together: slot 0 gets a bubble, no double insertion.
- Lookup for port p (combinational):
  - Match = lowest index i with v[i] & wa[i]==rs_addr[p] & rs_addr[p]!=0. The youngest producer wins; older matching slots are ignored.
  - rs_addr[p]==0: fwd_data=0, fwd_ready=1, never stalls.
  - No match: fwd_data=rf_rdata[p], fwd_ready=1.
  - Match with tn[i]==0: fwd_data=stage_data[i], fwd_ready=1.
  - Match with tn[i]>0: fwd_data=stage_data[i] (don't-care), fwd_ready=0.
  - Match with tn[i] > rs_tuse[p]: port requests stall.
- stall = OR of port stall requests | (issue_valid & issue_md_use & md_busy).
- MDU counter:
  - Accepted issue_md_start loads md_cnt=MDU_LAT at the edge.
  - Otherwise, if md_cnt≠0, it decrements by 1.
  - md_busy = (md_cnt≠0).
  - An MDU instruction in D while busy stalls, because md_use is asserted for it; there is no queuing.
- Tnew saturates at 0 and never wraps.
- No other sequential outputs; all outputs are combinational from state and inputs.
- Arithmetic is unsigned throughout.

Test Plan:
- Reset asserted mid-stream with 3 valid slots and md_cnt=3 → next cycle v=000, md_busy=0. With rs_addr={5,0} and rf_rdata={0xAAAA,0x1234}: fwd_data={0xAAAA, 0} (port 0 has address 5, port 1 has address 0), stall=0.
- Load-use: issue lw wa=8 tnew=2, then D reads r8 with tuse=0 → stall=1 for 2 cycles, one bubble per cycle. In the third cycle r8 matches slot 2 with tn=0, giving fwd_data=stage_data[2]=0xDEADBEEF and stall=0.
- ALU chain: addu wa=3 tnew=1, then D reads r3 with tuse=1 → no stall and fwd_ready=0 in D. Next cycle a second port reading r3 from slot 1 gets the forwarded value.
- Double producer: r4 written by slot 2 (0x11) and slot 0 (tn=0, 0x22) → fwd_data=0x22.
- MDU: accepted mult at cycle 0 (MDU_LAT=5), mfhi in D at cycles 1-5 → stall=1 at cycles 1-5, released at cycle 6 with md_busy=0.
- flush=1 with issue_valid=1 and wa=7 → slot 0 is a bubble, and a later read of r7 is not forwarded (returns rf_rdata).

Source files
------------

// File: rtl/fwd_scoreboard.sv
// D-stage operand forwarding/stall unit: tracks in-flight producers (dest, Tnew)
// per pipeline slot and resolves each read port to a forwarded value or a stall.
module fwd_scoreboard #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int NSTG    = 3,
  parameter int NRP     = 2,
  parameter int TW      = 3,
  parameter int MDU_LAT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_wa,
  input  logic [TW-1:0]       issue_tnew,
  input  logic                issue_md_start,
  input  logic                issue_md_use,
  input  logic                flush,
  input  logic [NRP*AW-1:0]   rs_addr,
  input  logic [NRP*TW-1:0]   rs_tuse,
  input  logic [NRP*DW-1:0]   rf_rdata,
  input  logic [NSTG*DW-1:0]  stage_data,
  output logic [NRP*DW-1:0]   fwd_data,
  output logic [NRP-1:0]      fwd_ready,
  output logic                stall,
  output logic                md_busy
);

  localparam int MW = $clog2(MDU_LAT + 1);

  logic [NSTG-1:0] vld_p;
  logic [AW-1:0]   wa_p [NSTG];
  logic [TW-1:0]   tn_p [NSTG];
  logic [MW-1:0]   md_cnt;

  logic [NRP-1:0]  hit;
  logic [NRP-1:0]  port_stall;
  logic [TW-1:0]   hit_tn   [NRP];
  logic [DW-1:0]   hit_data [NRP];
  logic            accept;

  function automatic logic [TW-1:0] sat0_dec(input logic [TW-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  // Lookup: scan oldest to youngest so the youngest matching slot wins
  always_comb begin
    hit        = '0;
    port_stall = '0;
    fwd_ready  = '1;
    fwd_data   = '0;
    for (int p = 0; p < NRP; p++) begin
      hit_tn[p]   = '0;
      hit_data[p] = '0;
      for (int i = NSTG - 1; i >= 0; i--) begin
        if (vld_p[i] && (wa_p[i] == rs_addr[p*AW +: AW]) && (rs_addr[p*AW +: AW] != '0)) begin
          hit[p]      = 1'b1;
          hit_tn[p]   = tn_p[i];
          hit_data[p] = stage_data[i*DW +: DW];
        end
      end
      if (rs_addr[p*AW +: AW] == '0) begin
        fwd_data[p*DW +: DW] = '0;
      end else if (hit[p]) begin
        fwd_data[p*DW +: DW] = hit_data[p];
        fwd_ready[p]         = (hit_tn[p] == '0);
        port_stall[p]        = (hit_tn[p] > rs_tuse[p*TW +: TW]);
      end else begin
        fwd_data[p*DW +: DW] = rf_rdata[p*DW +: DW];
      end
    end
  end

  assign md_busy = (md_cnt != '0);
  assign stall   = (|port_stall) | (issue_valid & issue_md_use & md_busy);
  assign accept  = issue_valid & ~stall & ~flush;

  // Slot shift: later stages never freeze; a stalled or flushed D inserts a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
      for (int i = 0; i < NSTG; i++) begin
        wa_p[i] <= '0;
        tn_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= accept;
      wa_p[0]  <= accept ? issue_wa   : '0;
      tn_p[0]  <= accept ? issue_tnew : '0;
      for (int i = 1; i < NSTG; i++) begin
        vld_p[i] <= vld_p[i-1];
        wa_p[i]  <= wa_p[i-1];
        tn_p[i]  <= sat0_dec(tn_p[i-1]);
      end
    end
  end

  // MDU busy countdown; a new accepted start reloads it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (accept && issue_md_start) begin
      md_cnt <= MW'(MDU_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios plus random traffic against an
// age-based model (per-cycle issue history, Tnew remaining = tnew - age).
module tb_fwd_scoreboard;
  localparam int DW = 32, AW = 5, NSTG = 3, NRP = 2, TW = 3, MDU_LAT = 5;
  localparam int NC = 8192;

  logic                clk = 1'b0;
  logic                reset;
  logic                issue_valid, issue_md_start, issue_md_use, flush;
  logic [AW-1:0]       issue_wa;
  logic [TW-1:0]       issue_tnew;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*TW-1:0]   rs_tuse;
  logic [NRP*DW-1:0]   rf_rdata;
  logic [NSTG*DW-1:0]  stage_data;
  logic [NRP*DW-1:0]   fwd_data;
  logic [NRP-1:0]      fwd_ready;
  logic                stall, md_busy;

  fwd_scoreboard #(.DW(DW), .AW(AW), .NSTG(NSTG), .NRP(NRP), .TW(TW), .MDU_LAT(MDU_LAT)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wa(issue_wa),
    .issue_tnew(issue_tnew), .issue_md_start(issue_md_start), .issue_md_use(issue_md_use),
    .flush(flush), .rs_addr(rs_addr), .rs_tuse(rs_tuse), .rf_rdata(rf_rdata),
    .stage_data(stage_data), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
    .stall(stall), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit acc_h [NC];
  logic [AW-1:0] wa_h [NC];
  int tn_h [NC];
  int cyc = 0, rst_cyc = 0, md_cyc = -100;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit model_md_busy();
    return (cyc - md_cyc >= 1) && (cyc - md_cyc <= MDU_LAT);
  endfunction

  task automatic set_idle();
    issue_valid = 0; issue_wa = '0; issue_tnew = '0; issue_md_start = 0; issue_md_use = 0;
    flush = 0; rs_addr = '0; rs_tuse = '0;
    for (int p = 0; p < NRP; p++) rf_rdata[p*DW +: DW] = $urandom;
    for (int i = 0; i < NSTG; i++) stage_data[i*DW +: DW] = $urandom;
  endtask

  task automatic rand_inputs();
    issue_valid    = ($urandom_range(0, 3) != 0);
    issue_wa       = AW'($urandom_range(0, 7));
    issue_tnew     = TW'($urandom_range(0, 4));
    issue_md_start = ($urandom_range(0, 15) == 0);
    issue_md_use   = issue_md_start | ($urandom_range(0, 9) == 0);
    flush          = ($urandom_range(0, 15) == 0);
    for (int p = 0; p < NRP; p++) begin
      rs_addr[p*AW +: AW]  = AW'($urandom_range(0, 7));
      rs_tuse[p*TW +: TW]  = TW'($urandom_range(0, 3));
      rf_rdata[p*DW +: DW] = $urandom;
    end
    for (int i = 0; i < NSTG; i++) stage_data[i*DW +: DW] = $urandom;
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, then commits at the edge
  task automatic step();
    bit m_stall, hit, exp_r, accept;
    int slot, tn, c, tuse;
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_d;
    #3;
    m_stall = model_md_busy() && issue_valid && issue_md_use;
    for (int p = 0; p < NRP; p++) begin
      addr = rs_addr[p*AW +: AW];
      tuse = int'(rs_tuse[p*TW +: TW]);
      hit = 0; slot = 0; tn = 0;
      if (addr != '0) begin
        for (int i = 0; i < NSTG; i++) begin
          c = cyc - 1 - i;
          if (!hit && c >= 0 && c >= rst_cyc && acc_h[c] && wa_h[c] == addr) begin
            hit = 1; slot = i; tn = (tn_h[c] > i) ? tn_h[c] - i : 0;
          end
        end
      end
      if (addr == '0) begin
        exp_d = '0; exp_r = 1;
      end else if (hit) begin
        exp_d = stage_data[slot*DW +: DW]; exp_r = (tn == 0);
        if (tn > tuse) m_stall = 1;
      end else begin
        exp_d = rf_rdata[p*DW +: DW]; exp_r = 1;
      end
      check($sformatf("fwd_ready[%0d]", p), 32'(fwd_ready[p]), 32'(exp_r));
      if (exp_r) check($sformatf("fwd_data[%0d]", p), fwd_data[p*DW +: DW], exp_d);
    end
    check("stall", 32'(stall), 32'(m_stall));
    check("md_busy", 32'(md_busy), 32'(model_md_busy()));
    accept = issue_valid && !m_stall && !flush;
    @(posedge clk);
    acc_h[cyc] = accept; wa_h[cyc] = issue_wa; tn_h[cyc] = int'(issue_tnew);
    if (accept && issue_md_start) md_cyc = cyc;
    cyc++;
    #1;
  endtask

  // Asynchronous reset pulse inside the current cycle
  task automatic reset_pulse();
    #1 reset = 1;
    #1;
    rst_cyc = cyc; md_cyc = -100;
    reset = 0;
  endtask

  initial begin
    set_idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rs_addr[0 +: AW] = 5'd9; rs_addr[AW +: AW] = 5'd0;
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);
    check("rst_ready", 32'(fwd_ready), 32'b11);
    check("rst_data0", fwd_data[0 +: DW], rf_rdata[0 +: DW]);
    check("rst_data1", fwd_data[DW +: DW], 32'd0);
    #1;

    // Reset mid-stream with three valid slots and md_cnt = 3
    set_idle();
    issue_valid = 1; issue_md_start = 1; issue_md_use = 1; issue_wa = 5'd5; issue_tnew = 3'd2;
    step();
    issue_md_start = 0; issue_md_use = 0; issue_wa = 5'd5; issue_tnew = 3'd1;
    step();
    step();
    issue_valid = 0;
    rs_addr[0 +: AW] = 5'd5; rs_addr[AW +: AW] = 5'd0; rs_tuse = '1;
    rf_rdata[0 +: DW] = 32'hAAAA; rf_rdata[DW +: DW] = 32'h1234;
    #1;
    check("pre_rst_busy", 32'(md_busy), 32'd1);
    reset_pulse();
    check("midrst_busy", 32'(md_busy), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_data0", fwd_data[0 +: DW], 32'hAAAA);
    check("midrst_data1", fwd_data[DW +: DW], 32'd0);
    step();
    step();

    // Load-use: lw r8 tnew=2, consumer tuse=0 stalls two cycles
    set_idle();
    issue_valid = 1; issue_wa = 5'd8; issue_tnew = 3'd2;
    step();
    issue_wa = 5'd9; issue_tnew = 3'd1; rs_addr[0 +: AW] = 5'd8;
    stage_data[2*DW +: DW] = 32'hDEADBEEF;
    #1 check("lu_stall1", 32'(stall), 32'd1);
    #0 step();
    #1 check("lu_stall2", 32'(stall), 32'd1);
    #0 step();
    #1 check("lu_stall3", 32'(stall), 32'd0);
    check("lu_data", fwd_data[0 +: DW], 32'hDEADBEEF);
    #0 step();

    // ALU chain: addu r3 tnew=1, consumer with tuse=1 proceeds without data yet
    set_idle();
    issue_valid = 1; issue_wa = 5'd3; issue_tnew = 3'd1;
    step();
    issue_wa = 5'd10; rs_addr[0 +: AW] = 5'd3; rs_tuse[0 +: TW] = 3'd1;
    #1 check("alu_stall", 32'(stall), 32'd0);
    check("alu_notready", 32'(fwd_ready[0]), 32'd0);
    #0 step();
    rs_addr = '0; rs_addr[AW +: AW] = 5'd3; stage_data[1*DW +: DW] = 32'h0BADF00D;
    #1 check("alu_fwd", fwd_data[DW +: DW], 32'h0BADF00D);
    #0 step();

    // Double producer of r4: youngest wins
    set_idle();
    issue_valid = 1; issue_wa = 5'd4; issue_tnew = 3'd0;
    step();
    issue_wa = 5'd5;
    step();
    issue_wa = 5'd4;
    step();
    issue_valid = 0; rs_addr[0 +: AW] = 5'd4;
    stage_data[0 +: DW] = 32'h22; stage_data[2*DW +: DW] = 32'h11;
    #1 check("dbl_data", fwd_data[0 +: DW], 32'h22);
    #0 step();

    // MDU: mult then mfhi stalls while busy
    set_idle();
    issue_valid = 1; issue_md_start = 1; issue_md_use = 1; issue_wa = 5'd0;
    step();
    issue_md_start = 0; issue_wa = 5'd2; issue_tnew = 3'd1;
    for (int k = 1; k <= MDU_LAT; k++) begin
      #1 check($sformatf("md_stall_c%0d", k), 32'(stall), 32'd1);
      #0 step();
    end
    #1 check("md_release", 32'(stall), 32'd0);
    check("md_idle", 32'(md_busy), 32'd0);
    #0 step();

    // Flush turns an issued writer of r7 into a bubble
    set_idle();
    issue_valid = 1; issue_wa = 5'd7; issue_tnew = 3'd0; flush = 1;
    step();
    flush = 0; issue_valid = 0; rs_addr[0 +: AW] = 5'd7;
    #1 check("flush_nofwd", fwd_data[0 +: DW], rf_rdata[0 +: DW]);
    #0 step();

    // Random traffic with occasional asynchronous reset
    for (int n = 0; n < 1500; n++) begin
      rand_inputs();
      if ($urandom_range(0, 199) == 0) reset_pulse();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
